tx_frame_builder: RTL and testbench

Synthesizable PCD/PICC transmit frame builder. It accepts a byte stream and serialises it LSb first into one bit per beat. It inserts odd parity after each byte, optionally appends CRC_A (little-endian), and supports a partial first byte for anticollision and short frames. It sits between the protocol layer and the line encoder, and is the RTL counterpart of the bench's frame-generation model, generalised with a buffered input, run-time modes and backpressure.

---
 rtl/ISO14443A_pkg.sv | 26 ++
 rtl/byte_fifo.sv | 64 ++++++
 rtl/tx_frame_builder.sv | 171 +++++++++++++++++
 tb/tb_tx_frame_builder.sv | 228 ++++++++++++++++++++++
 4 files changed

// File: rtl/ISO14443A_pkg.sv
// Shared ISO/IEC 14443-A definitions: CRC_A preset, the CRC_A byte update
// and the transmit frame builder state encoding.
package ISO14443A_pkg;

  localparam logic [15:0] CRC_A_INIT = 16'h6363;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_DATA,
    ST_CRC_LO,
    ST_CRC_HI
  } builder_state_e;

  // Reflected CRC-16 (poly 0x8408), one data byte folded in LSb first.
  function automatic logic [15:0] crc_a_update(input logic [15:0] crc,
                                               input logic [7:0]  data);
    logic [15:0] c;
    c = crc;
    for (int i = 0; i < 8; i++) begin
      if (c[0] ^ data[i]) c = (c >> 1) ^ 16'h8408;
      else                c = c >> 1;
    end
    return c;
  endfunction

endpackage

// File: rtl/byte_fifo.sv
// Small synchronous FIFO with registered full/empty flags; pointers wrap
// naturally because DEPTH is a power of two.
module byte_fifo #(
  parameter int WIDTH = 9,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             pop,
  output logic [WIDTH-1:0] rd_data,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [AW:0]      count_q, count_d;
  logic             full_q, full_d, empty_q, empty_d;
  logic             do_push, do_pop;

  always_comb begin
    do_push  = push && !full_q;
    do_pop   = pop && !empty_q;
    wr_ptr_d = do_push ? wr_ptr_q + 1'b1 : wr_ptr_q;
    rd_ptr_d = do_pop ? rd_ptr_q + 1'b1 : rd_ptr_q;
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
    full_d  = (count_d == FULL_CNT);
    empty_d = (count_d == '0);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      full_q   <= 1'b0;
      empty_q  <= 1'b1;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      full_q   <= full_d;
      empty_q  <= empty_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= wr_data;
  end

  assign rd_data = mem_q[rd_ptr_q];
  assign full    = full_q;
  assign empty   = empty_q;

endmodule

// File: rtl/tx_frame_builder.sv
// ISO 14443-A transmit frame builder: buffers bytes, serialises them LSb first
// with optional odd parity and a trailing little-endian CRC_A.
module tx_frame_builder
  import ISO14443A_pkg::*;
#(
  parameter int          FIFO_DEPTH = 4,
  parameter logic [15:0] CRC_INIT   = CRC_A_INIT
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] in_data,
  input  logic       in_valid,
  output logic       in_ready,
  input  logic       in_last,
  input  logic [2:0] cfg_bits_first,
  input  logic       cfg_crc,
  input  logic       cfg_parity,
  output logic       out_bit,
  output logic       out_valid,
  input  logic       out_ready,
  output logic       out_last,
  output logic       out_is_parity,
  output logic       busy,
  output logic       underrun
);

  builder_state_e state_q, state_d;
  logic [7:0]  shreg_q, shreg_d;
  logic [2:0]  rem_q, rem_d;
  logic [15:0] crc_q, crc_d;
  logic par_acc_q, par_acc_d, byte_last_q, byte_last_d, byte_final_q, byte_final_d;
  logic cfg_crc_q, cfg_crc_d, cfg_parity_q, cfg_parity_d;
  logic out_valid_q, out_valid_d, out_bit_q, out_bit_d, out_last_q, out_last_d;
  logic out_is_parity_q, out_is_parity_d, busy_q, busy_d, underrun_q, underrun_d;

  logic [8:0] fifo_rd_data;
  logic       fifo_full, fifo_empty, fifo_pop;
  logic       fire, byte_done, start_frame, next_data, end_frame, load_en, load_final;
  logic [7:0] load_byte;
  logic [2:0] load_rem;

  byte_fifo #(.WIDTH(9), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .push    (in_valid),
    .wr_data ({in_last, in_data}),
    .pop     (fifo_pop),
    .rd_data (fifo_rd_data),
    .full    (fifo_full),
    .empty   (fifo_empty)
  );

  always_comb begin
    state_d = state_q;           shreg_d = shreg_q;           rem_d = rem_q;
    crc_d = crc_q;               par_acc_d = par_acc_q;       byte_last_d = byte_last_q;
    byte_final_d = byte_final_q; cfg_crc_d = cfg_crc_q;       cfg_parity_d = cfg_parity_q;
    out_valid_d = out_valid_q;   out_bit_d = out_bit_q;       out_last_d = out_last_q;
    out_is_parity_d = out_is_parity_q;
    underrun_d = 1'b0;           fifo_pop = 1'b0;
    fire = out_valid_q && out_ready;
    byte_done = 1'b0; start_frame = 1'b0; next_data = 1'b0; end_frame = 1'b0;
    load_en = 1'b0; load_byte = '0; load_rem = 3'd7; load_final = 1'b0;

    // out_valid low outside IDLE only happens while DATA waits on an empty FIFO.
    case (state_q)
      ST_IDLE: start_frame = !fifo_empty;
      default: begin
        if (!out_valid_q) begin
          next_data = (state_q == ST_DATA) && !fifo_empty;
        end else if (fire) begin
          if (!out_is_parity_q && rem_q != 3'd0) begin
            out_bit_d  = shreg_q[0];
            shreg_d    = shreg_q >> 1;
            rem_d      = rem_q - 3'd1;
            par_acc_d  = par_acc_q ^ out_bit_q;
            out_last_d = (rem_q == 3'd1) && byte_final_q && !cfg_parity_q;
          end else if (!out_is_parity_q && cfg_parity_q) begin
            out_bit_d       = ~(par_acc_q ^ out_bit_q);
            out_is_parity_d = 1'b1;
            out_last_d      = byte_final_q;
          end else begin
            byte_done = 1'b1;
          end
        end
      end
    endcase

    if (byte_done) begin
      case (state_q)
        ST_DATA: begin
          if (!byte_last_q) begin
            if (!fifo_empty) next_data = 1'b1;
            else begin
              out_valid_d = 1'b0; out_is_parity_d = 1'b0; out_last_d = 1'b0;
              underrun_d  = 1'b1;
            end
          end else if (cfg_crc_q) begin
            state_d = ST_CRC_LO; load_en = 1'b1; load_byte = crc_q[7:0];
          end else begin
            end_frame = 1'b1;
          end
        end
        ST_CRC_LO: begin
          state_d = ST_CRC_HI; load_en = 1'b1; load_byte = crc_q[15:8]; load_final = 1'b1;
        end
        ST_CRC_HI: end_frame = 1'b1;
        default: ;
      endcase
    end

    // A queued frame starts straight away so frames run back to back.
    if (end_frame) begin
      if (!fifo_empty) start_frame = 1'b1;
      else begin
        state_d = ST_IDLE; out_valid_d = 1'b0; out_bit_d = 1'b0;
        out_last_d = 1'b0; out_is_parity_d = 1'b0; crc_d = CRC_INIT;
      end
    end

    if (start_frame) begin
      fifo_pop = 1'b1; state_d = ST_DATA;
      cfg_crc_d = cfg_crc; cfg_parity_d = cfg_parity;
      crc_d = crc_a_update(CRC_INIT, fifo_rd_data[7:0]);
      byte_last_d = fifo_rd_data[8];
      load_en = 1'b1; load_byte = fifo_rd_data[7:0];
      load_rem = (cfg_bits_first == 3'd0) ? 3'd7 : cfg_bits_first - 3'd1;
      load_final = fifo_rd_data[8] && !cfg_crc;
    end

    if (next_data) begin
      fifo_pop = 1'b1;
      crc_d = crc_a_update(crc_q, fifo_rd_data[7:0]);
      byte_last_d = fifo_rd_data[8];
      load_en = 1'b1; load_byte = fifo_rd_data[7:0];
      load_final = fifo_rd_data[8] && !cfg_crc_q;
    end

    if (load_en) begin
      out_valid_d = 1'b1; out_bit_d = load_byte[0]; shreg_d = {1'b0, load_byte[7:1]};
      rem_d = load_rem; par_acc_d = 1'b0; out_is_parity_d = 1'b0; byte_final_d = load_final;
      out_last_d = (load_rem == 3'd0) && load_final && !cfg_parity_d;
    end

    busy_d = (state_d != ST_IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;  shreg_q <= '0;  rem_q <= '0;  crc_q <= CRC_INIT;
      par_acc_q <= 1'b0;   byte_last_q <= 1'b0;   byte_final_q <= 1'b0;
      cfg_crc_q <= 1'b0;   cfg_parity_q <= 1'b0;
      out_valid_q <= 1'b0; out_bit_q <= 1'b0;     out_last_q <= 1'b0;
      out_is_parity_q <= 1'b0; busy_q <= 1'b0;    underrun_q <= 1'b0;
    end else begin
      state_q <= state_d;  shreg_q <= shreg_d;  rem_q <= rem_d;  crc_q <= crc_d;
      par_acc_q <= par_acc_d;     byte_last_q <= byte_last_d;   byte_final_q <= byte_final_d;
      cfg_crc_q <= cfg_crc_d;     cfg_parity_q <= cfg_parity_d;
      out_valid_q <= out_valid_d; out_bit_q <= out_bit_d;       out_last_q <= out_last_d;
      out_is_parity_q <= out_is_parity_d; busy_q <= busy_d;     underrun_q <= underrun_d;
    end
  end

  assign in_ready      = !fifo_full;
  assign out_bit       = out_bit_q;
  assign out_valid     = out_valid_q;
  assign out_last      = out_last_q;
  assign out_is_parity = out_is_parity_q;
  assign busy          = busy_q;
  assign underrun      = underrun_q;

endmodule

// File: tb/tb_tx_frame_builder.sv
// Directed bench for tx_frame_builder: short frames, parity, CRC_A,
// backpressure, underrun, back-to-back frames and reset mid-frame.
module tb_tx_frame_builder;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [7:0] in_data;
  logic       in_valid, in_ready, in_last;
  logic [2:0] cfg_bits_first;
  logic       cfg_crc, cfg_parity;
  logic       out_bit, out_valid, out_ready, out_last, out_is_parity, busy, underrun;

  tx_frame_builder dut (
    .clk(clk), .rst_n(rst_n), .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
    .in_last(in_last), .cfg_bits_first(cfg_bits_first), .cfg_crc(cfg_crc),
    .cfg_parity(cfg_parity), .out_bit(out_bit), .out_valid(out_valid), .out_ready(out_ready),
    .out_last(out_last), .out_is_parity(out_is_parity), .busy(busy), .underrun(underrun)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] data;
    logic       last;
    int         delay;
  } inByte_t;

  inByte_t     inQ[$];
  logic [63:0] obsBits, obsPar, obsLast, expBits, expPar, expLast;
  int          obsCount, expCount;
  int          testCount = 0;
  int          failCount = 0;
  int          cycleCount = 0;
  int          underrunCount, holdViolations, gapCycles, lastSeen, firstBitCycle, lastBitCycle;
  bit          randomReady, sawFull, holdPending;
  logic        holdBit, holdPar, holdLast;

  task automatic checkOutput(input string tag, input logic [63:0] observed,
                             input logic [63:0] expected);
    testCount++;
    assert (observed === expected) else begin
      failCount++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
    end
  endtask

  task automatic clearRecord();
    obsBits = '0; obsPar = '0; obsLast = '0; obsCount = 0;
    expBits = '0; expPar = '0; expLast = '0; expCount = 0;
    underrunCount = 0; holdViolations = 0; gapCycles = 0; lastSeen = 0;
    firstBitCycle = -1; lastBitCycle = -1; sawFull = 0; holdPending = 0;
  endtask

  // Expected serialisation of one byte: nBits LSb first, then odd parity.
  task automatic addByte(input logic [7:0] data, input int nBits, input bit withParity,
                         input bit finalByte);
    logic p;
    p = 1'b1;
    for (int i = 0; i < nBits; i++) begin
      expBits[expCount] = data[i]; expPar[expCount] = 1'b0; expLast[expCount] = 1'b0;
      p = p ^ data[i];
      expCount++;
    end
    if (withParity) begin
      expBits[expCount] = p; expPar[expCount] = 1'b1; expLast[expCount] = 1'b0;
      expCount++;
    end
    if (finalByte) expLast[expCount-1] = 1'b1;
  endtask

  task automatic applyStimulus();
    @(negedge clk);
    cycleCount++;
    if (holdPending && (out_valid !== 1'b1 || out_bit !== holdBit ||
                        out_is_parity !== holdPar || out_last !== holdLast))
      holdViolations++;
    if (underrun === 1'b1) underrunCount++;
    if (in_ready === 1'b0) sawFull = 1;
    if (firstBitCycle >= 0 && out_valid === 1'b0 && busy === 1'b1) gapCycles++;
    in_valid = 1'b0;
    if (inQ.size() > 0) begin
      if (inQ[0].delay > 0) inQ[0].delay = inQ[0].delay - 1;
      else begin
        in_valid = 1'b1; in_data = inQ[0].data; in_last = inQ[0].last;
        if (in_ready === 1'b1) void'(inQ.pop_front());
      end
    end
    out_ready = randomReady ? 1'($urandom_range(0, 1)) : 1'b1;
    if (out_valid === 1'b1 && out_ready) begin
      if (obsCount < 64) begin
        obsBits[obsCount] = out_bit; obsPar[obsCount] = out_is_parity;
        obsLast[obsCount] = out_last;
      end
      obsCount++;
      if (firstBitCycle < 0) firstBitCycle = cycleCount;
      lastBitCycle = cycleCount;
      if (out_last === 1'b1) lastSeen++;
    end
    holdPending = (out_valid === 1'b1) && !out_ready;
    holdBit = out_bit; holdPar = out_is_parity; holdLast = out_last;
  endtask

  task automatic runUntil(input string tag, input int nLast, input int budget);
    for (int c = 0; c < budget && lastSeen < nLast; c++) applyStimulus();
    checkOutput({tag, " frames done"}, 64'(lastSeen), 64'(nLast));
    randomReady = 0;
    repeat (3) applyStimulus();
  endtask

  task automatic compareFrame(input string tag);
    checkOutput({tag, " bits"}, obsBits, expBits);
    checkOutput({tag, " parity flags"}, obsPar, expPar);
    checkOutput({tag, " last flags"}, obsLast, expLast);
    checkOutput({tag, " bit count"}, 64'(obsCount), 64'(expCount));
  endtask

  task automatic checkResetValues(input string tag);
    checkOutput({tag, " in_ready"}, 64'(in_ready), 64'd1);
    checkOutput({tag, " out_valid"}, 64'(out_valid), 64'd0);
    checkOutput({tag, " out_bit"}, 64'(out_bit), 64'd0);
    checkOutput({tag, " out_last"}, 64'(out_last), 64'd0);
    checkOutput({tag, " out_is_parity"}, 64'(out_is_parity), 64'd0);
    checkOutput({tag, " busy"}, 64'(busy), 64'd0);
    checkOutput({tag, " underrun"}, 64'(underrun), 64'd0);
  endtask

  task automatic setCfg(input logic [2:0] bits, input logic par, input logic crc);
    cfg_bits_first = bits; cfg_parity = par; cfg_crc = crc;
  endtask

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; in_data = '0; in_last = 1'b0; out_ready = 1'b1;
    randomReady = 0;
    setCfg(3'd0, 1'b0, 1'b0);
    clearRecord();
    repeat (3) @(negedge clk);
    checkResetValues("reset");
    rst_n = 1'b1;

    // REQA short frame: 0x26, 7 bits, no parity, no CRC.
    clearRecord(); setCfg(3'd7, 1'b0, 1'b0);
    inQ.push_back('{8'h26, 1'b1, 0});
    addByte(8'h26, 7, 0, 1);
    runUntil("reqa", 1, 60);
    compareFrame("reqa");
    checkOutput("reqa busy after frame", 64'(busy), 64'd0);

    // Single byte with parity.
    clearRecord(); setCfg(3'd0, 1'b1, 1'b0);
    inQ.push_back('{8'h93, 1'b1, 0});
    addByte(8'h93, 8, 1, 1);
    runUntil("parity", 1, 60);
    compareFrame("parity");

    // 0x00 0x00 with CRC_A 0xA0 0x1E, parity on, 36 contiguous beats.
    clearRecord(); setCfg(3'd0, 1'b1, 1'b1);
    inQ.push_back('{8'h00, 1'b0, 0}); inQ.push_back('{8'h00, 1'b1, 0});
    addByte(8'h00, 8, 1, 0); addByte(8'h00, 8, 1, 0);
    addByte(8'hA0, 8, 1, 0); addByte(8'h1E, 8, 1, 1);
    runUntil("crc0000", 1, 120);
    compareFrame("crc0000");
    checkOutput("crc0000 beats", 64'(lastBitCycle - firstBitCycle + 1), 64'd36);
    checkOutput("crc0000 no underrun", 64'(underrunCount), 64'd0);

    // 0x12 0x34 with CRC_A 0x26 0xCF.
    clearRecord(); setCfg(3'd0, 1'b1, 1'b1);
    inQ.push_back('{8'h12, 1'b0, 0}); inQ.push_back('{8'h34, 1'b1, 0});
    addByte(8'h12, 8, 1, 0); addByte(8'h34, 8, 1, 0);
    addByte(8'h26, 8, 1, 0); addByte(8'hCF, 8, 1, 1);
    runUntil("crc1234", 1, 120);
    compareFrame("crc1234");

    // Same frame under random backpressure.
    clearRecord(); setCfg(3'd0, 1'b1, 1'b1); randomReady = 1;
    inQ.push_back('{8'h12, 1'b0, 0}); inQ.push_back('{8'h34, 1'b1, 0});
    addByte(8'h12, 8, 1, 0); addByte(8'h34, 8, 1, 0);
    addByte(8'h26, 8, 1, 0); addByte(8'hCF, 8, 1, 1);
    runUntil("backpressure", 1, 600);
    compareFrame("backpressure");
    checkOutput("backpressure hold stable", 64'(holdViolations), 64'd0);

    // Second byte withheld long enough to drain the FIFO mid-frame.
    clearRecord(); setCfg(3'd0, 1'b1, 1'b0);
    inQ.push_back('{8'h93, 1'b0, 0}); inQ.push_back('{8'h26, 1'b1, 15});
    addByte(8'h93, 8, 1, 0); addByte(8'h26, 8, 1, 1);
    runUntil("underrun", 1, 120);
    compareFrame("underrun");
    checkOutput("underrun pulse count", 64'(underrunCount), 64'd1);
    checkOutput("underrun out_valid gap", 64'(gapCycles > 0), 64'd1);

    // Two queued frames with different configs, FIFO fills, no idle beat.
    clearRecord(); setCfg(3'd0, 1'b1, 1'b1);
    inQ.push_back('{8'h12, 1'b0, 0}); inQ.push_back('{8'h34, 1'b1, 0});
    inQ.push_back('{8'h93, 1'b0, 0}); inQ.push_back('{8'h26, 1'b0, 0});
    inQ.push_back('{8'h01, 1'b1, 0});
    addByte(8'h12, 8, 1, 0); addByte(8'h34, 8, 1, 0);
    addByte(8'h26, 8, 1, 0); addByte(8'hCF, 8, 1, 1);
    addByte(8'h93, 5, 0, 0); addByte(8'h26, 8, 0, 0); addByte(8'h01, 8, 0, 1);
    repeat (4) applyStimulus();
    setCfg(3'd5, 1'b0, 1'b0);
    runUntil("b2b", 2, 200);
    compareFrame("b2b");
    checkOutput("b2b fifo full seen", 64'(sawFull), 64'd1);
    checkOutput("b2b contiguous beats", 64'(lastBitCycle - firstBitCycle + 1), 64'd57);
    checkOutput("b2b no underrun", 64'(underrunCount), 64'd0);

    // Reset after three bits, with a second byte still buffered.
    clearRecord(); setCfg(3'd0, 1'b1, 1'b0);
    inQ.push_back('{8'h93, 1'b0, 0}); inQ.push_back('{8'h55, 1'b0, 0});
    for (int c = 0; c < 60 && obsCount < 3; c++) applyStimulus();
    checkOutput("midreset bits before reset", 64'(obsCount), 64'd3);
    inQ.delete(); in_valid = 1'b0;
    #2 rst_n = 1'b0;
    #1 checkResetValues("midreset");
    @(negedge clk); @(negedge clk);
    rst_n = 1'b1;

    clearRecord(); setCfg(3'd7, 1'b0, 1'b0);
    inQ.push_back('{8'h26, 1'b1, 0});
    addByte(8'h26, 7, 0, 1);
    runUntil("postreset", 1, 60);
    compareFrame("postreset");

    $display("[TB] %0d tests run, %0d failed", testCount, failCount);
    $finish;
  end

endmodule
